// File: rtl/regwr_arbiter.sv
// Arbitrates the register-file write port between WB (priority) and a FIFO of MC results,
// and keeps the per-register busy scoreboard for ID stalls. Optional macro: REGWR_BYPASS_EN.
module regwr_arbiter #(
    parameter int REG_NUM   = 32,
    parameter int REG_ADDRW = 5,
    parameter int DWIDTH    = 32,
    parameter int QDEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_valid,
    input  logic [REG_ADDRW-1:0]       wb_num,
    input  logic [DWIDTH-1:0]          wb_data,
    input  logic                       mc_valid,
    output logic                       mc_ready,
    input  logic [REG_ADDRW-1:0]       mc_num,
    input  logic [DWIDTH-1:0]          mc_data,
    input  logic                       mc_issue,
    input  logic [REG_ADDRW-1:0]       mc_issue_num,
    input  logic [REG_ADDRW-1:0]       id_rs1,
    input  logic [REG_ADDRW-1:0]       id_rs2,
    input  logic [REG_ADDRW-1:0]       id_rd,
    output logic                       id_stall,
    output logic                       rf_wr_en,
    output logic [REG_ADDRW-1:0]       rf_wr_num,
    output logic [DWIDTH-1:0]          rf_wr_data,
    output logic [$clog2(QDEPTH):0]    q_count
);
    localparam int PTRW = $clog2(QDEPTH);
    localparam int CW   = PTRW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    logic [REG_ADDRW-1:0] fifo_num_q  [QDEPTH];
    logic [DWIDTH-1:0]    fifo_data_q [QDEPTH];
    logic [PTRW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic [REG_NUM-1:0]   busy_q, busy_d;
    logic                 rf_en_q, rf_en_d;
    logic [REG_ADDRW-1:0] rf_num_q, rf_num_d;
    logic [DWIDTH-1:0]    rf_data_q, rf_data_d;

    logic wb_take, fifo_empty, mc_acc, bypass, push, pop;

    assign wb_take    = wb_valid && (wb_num != '0);
    assign fifo_empty = (count_q == '0);
    assign mc_ready   = (count_q < DEPTH_C);
    assign mc_acc     = mc_valid && mc_ready;

`ifdef REGWR_BYPASS_EN
    // An MC result may skip the FIFO only when nothing older could be waiting for the port.
    assign bypass = mc_acc && (mc_num != '0) && fifo_empty && !wb_take;
`else
    assign bypass = 1'b0;
`endif

    assign pop  = !wb_take && !fifo_empty;
    assign push = mc_acc && (mc_num != '0) && !bypass;

    assign id_stall   = busy_q[id_rs1] | busy_q[id_rs2] | busy_q[id_rd];
    assign rf_wr_en   = rf_en_q;
    assign rf_wr_num  = rf_num_q;
    assign rf_wr_data = rf_data_q;
    assign q_count    = count_q;

    always_comb begin
        rf_en_d   = 1'b0;
        rf_num_d  = rf_num_q;
        rf_data_d = rf_data_q;
        busy_d    = busy_q;
        if (wb_take) begin
            rf_en_d   = 1'b1;
            rf_num_d  = wb_num;
            rf_data_d = wb_data;
        end else if (pop) begin
            rf_en_d   = 1'b1;
            rf_num_d  = fifo_num_q[rd_ptr_q];
            rf_data_d = fifo_data_q[rd_ptr_q];
            busy_d[fifo_num_q[rd_ptr_q]] = 1'b0;
        end else if (bypass) begin
            rf_en_d   = 1'b1;
            rf_num_d  = mc_num;
            rf_data_d = mc_data;
            busy_d[mc_num] = 1'b0;
        end
        // A new issue on the same edge as the retiring write keeps the register busy.
        if (mc_issue && (mc_issue_num != '0)) begin
            busy_d[mc_issue_num] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_en_q   <= 1'b0;
            rf_num_q  <= '0;
            rf_data_q <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            busy_q    <= '0;
        end else begin
            rf_en_q   <= rf_en_d;
            rf_num_q  <= rf_num_d;
            rf_data_q <= rf_data_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_num_q[wr_ptr_q]  <= mc_num;
            fifo_data_q[wr_ptr_q] <= mc_data;
        end
    end
endmodule
